div_shift_sub: RTL and testbench

DIV_SHIFT_SUB -- requirements
Module: div_shift_sub

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_datapath.sv | 66 ++++++
 rtl/div_shift_sub.sv | 88 ++++++++
 tb/tb_div_shift_sub.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: default width, FSM
// state encoding and the iteration-counter width.
package div_pkg;

  localparam int WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring divider datapath: dividend/quotient shift register, divisor,
// partial remainder and the WIDTH+1 bit trial subtractor.
module div_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             step,
  output logic             b_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             div0_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign b_zero  = (datain == '0);
  // The dividend shifts out of the top of quo_q while quotient bits enter at the bottom.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      div0_q <= 1'b0;
    end else if (load_a) begin
      quo_q  <= datain;
      rem_q  <= '0;
      div0_q <= 1'b0;
    end else if (load_b) begin
      if (b_zero) begin
        rem_q  <= quo_q;
        quo_q  <= '1;
        dvs_q  <= '0;
        div0_q <= 1'b1;
      end else begin
        dvs_q <= datain;
        rem_q <= '0;
      end
    end else if (step) begin
      // A clear top bit means the trial difference did not borrow.
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div0      = div0_q;

endmodule

// File: rtl/div_shift_sub.sv
// Unsigned shift-subtract divider: operands arrive serially on datain,
// one quotient bit is produced per clock.
//
// state    | meaning
// S_IDLE   | waiting for start; dividend captured when start=1
// S_LOAD_B | divisor captured; zero divisor short-circuits to S_DONE
// S_RUN    | WIDTH iterations, one quotient bit per edge
// S_DONE   | results held; start begins the next division
module div_shift_sub #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  import div_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            load_a;
  logic            load_b;
  logic            step;
  logic            b_zero;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (load_b) cnt <= '0;
    else if (step)   cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    step     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_a   = 1'b1;
          state_nx = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        load_b   = 1'b1;
        state_nx = b_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_LOAD_B) || (state == S_RUN);
  assign done = (state == S_DONE);

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .datain    (datain),
    .load_a    (load_a),
    .load_b    (load_b),
    .step      (step),
    .b_zero    (b_zero),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

endmodule

// File: tb/tb_div_shift_sub.sv
// Scoreboard bench for div_shift_sub: the driver queues hand-computed results,
// a monitor pops and compares each time done rises.
module tb_div_shift_sub;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        d0;
    int          lat;
    int          e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] datain = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  logic done_q = 1'b0;
  exp_t sb[$];

  div_shift_sub #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .datain    (datain),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div0", 32'(div0), 32'(e.d0));
        chk("latency", 32'(cycle - e.e0), 32'(e.lat));
      end
    end
    done_q <= rst ? 1'b0 : done;
  end

  // Called at a negedge: drives dividend, then divisor, returns one negedge after E1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input logic d0, input bit push);
    exp_t e;
    start  = 1'b1;
    datain = a;
    e.q = q; e.r = r; e.d0 = d0; e.lat = d0 ? 1 : 33; e.e0 = cycle + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    datain = b;
    @(negedge clk);
    datain = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic d0);
    @(negedge clk);
    issue(a, b, q, r, d0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_remainder", remainder, 32'h0);
    chk("rst_flags", {29'h0, busy, done, div0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd16, 32'd5, 32'd3, 32'd1, 1'b0);
    run_op(32'd5, 32'd16, 32'd0, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1);
    run_op(32'd0, 32'd7, 32'd0, 32'd0, 1'b0);
    run_op(32'd7, 32'd7, 32'd1, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_op(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0);
    chk("hold_busy", 32'(busy), 32'd0);

    // start and datain wiggled during RUN must be ignored.
    @(negedge clk);
    issue(32'd16, 32'd5, 32'd3, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      start  = 1'($urandom_range(0, 1));
      datain = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    issue(32'd16, 32'd5, 32'd3, 32'd1, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_quotient", quotient, 32'h0);
    chk("abort_remainder", remainder, 32'h0);
    chk("abort_flags", {29'h0, busy, done, div0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b1);
    wait_done();

    // Back-to-back: start accepted while done is high.
    @(negedge clk);
    issue(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_level", 32'(done), 32'd1);
    chk("hold_quotient", quotient, 32'd9);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
